// File: rtl/fp_wb_arbiter_pkg.sv
// Shared FP writeback types: FloPoCo result word, instruction id and class encoding.
package fp_wb_arbiter_pkg;

    localparam int FLOPOCO_W = 34;
    localparam int ID_W      = 4;

    typedef logic [FLOPOCO_W-1:0] flopoco_t;
    typedef logic [ID_W-1:0]      id_t;

    // Top two bits of a FloPoCo word: 00 zero, 01 normal, 10 inf, 11 NaN.
    localparam logic [1:0] FP_CLASS_NORMAL = 2'b01;

    function automatic logic is_special(input flopoco_t v);
        return v[FLOPOCO_W-1:FLOPOCO_W-2] != FP_CLASS_NORMAL;
    endfunction

endpackage

// File: rtl/fp_wb_arbiter_rr_grant.sv
// Round-robin selector: first set request at or after ptr, searching upward modulo N.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_grant #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Arbitrates FP unit results into a single registered commit slot for the FP regfile write port.
// Latency: 1 cycle from unit_ack to commit_valid; 1 result/cycle with commit_ready held high.
// Backpressure: while a held result is not accepted, unit_ack stays zero and the payload is frozen.
module fp_wb_arbiter
    import fp_wb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = 2,
    parameter int COUNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_UNITS-1:0]      unit_done,
    input  flopoco_t [NUM_UNITS-1:0]  unit_rd,
    input  id_t [NUM_UNITS-1:0]       unit_id,
    output logic [NUM_UNITS-1:0]      unit_ack,
    output logic                      commit_valid,
    input  logic                      commit_ready,
    output flopoco_t                  commit_rd,
    output id_t                       commit_id,
    output logic                      commit_special,
    output logic [COUNT_W-1:0]        commit_count
);

    localparam int PTR_W = $clog2(NUM_UNITS);

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_UNITS-1:0] grant;
    logic                 load;

    rr_grant #(
        .N     (NUM_UNITS),
        .PTR_W (PTR_W)
    ) u_rr_grant (
        .req   (unit_done),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign load = !commit_valid || commit_ready;

    // Gated by rst so no unit sees an ack (and drops its result) while we are in reset.
    assign unit_ack = (rst && load) ? grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_valid   <= 1'b0;
            commit_rd      <= '0;
            commit_id      <= '0;
            commit_special <= 1'b0;
            commit_count   <= '0;
            ptr            <= '0;
        end else begin
            if (commit_valid && commit_ready) begin
                commit_count <= commit_count + COUNT_W'(1);
            end
            if (load) begin
                if (|unit_done) begin
                    commit_valid   <= 1'b1;
                    commit_rd      <= unit_rd[grant_idx];
                    commit_id      <= unit_id[grant_idx];
                    commit_special <= is_special(unit_rd[grant_idx]);
                    ptr            <= (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0
                                                                           : grant_idx + PTR_W'(1);
                end else begin
                    commit_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 Parameter NUM_UNITS, default 2, SHALL set the number of FP result producers arbitrated (range 2..8).
REQ-002 Parameter COUNT_W, default 32, SHALL set the width of the commit performance counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port unit_done, input, NUM_UNITS bits: per-unit result valid (writeback-side view of wb.done).
REQ-006 Port unit_rd, input, NUM_UNITS x flopoco_t (34 bits): per-unit result, in FloPoCo format.
REQ-007 Port unit_id, input, NUM_UNITS x id_t: per-unit instruction id.
REQ-008 Port unit_ack, output, NUM_UNITS bits: per-unit result accepted (drives wb.ack).
REQ-009 Port commit_valid, output, 1 bit: registered result present.
REQ-010 Port commit_ready, input, 1 bit: FP register-file write port accepts the result this cycle.
REQ-011 Port commit_rd, output, flopoco_t: registered result.
REQ-012 Port commit_id, output, id_t: registered id.
REQ-013 Port commit_special, output, 1 bit: registered flag, set when commit_rd[33:32] != 2'b01 (zero, inf or NaN).
REQ-014 Port commit_count, output, COUNT_W bits: number of completed commits.

Function
REQ-015 load SHALL equal (!commit_valid || commit_ready).
REQ-016 The grant SHALL be round-robin: the first set unit_done bit at or after pointer ptr, searching upward modulo NUM_UNITS.
REQ-017 unit_ack SHALL be one-hot or zero, combinational, and equal to grant when load=1, otherwise zero.
REQ-018 unit_ack SHALL never assert for a unit whose unit_done=0.
REQ-019 On load with any unit_done set, the output register SHALL capture the granted unit's rd and id plus the derived special flag, and commit_valid SHALL become 1 next cycle.
REQ-020 On load with no unit_done set, commit_valid SHALL become 0 and the payload SHALL hold.
REQ-021 While commit_valid=1 and commit_ready=0, the payload SHALL be held stable and unit_ack SHALL be all zero.
REQ-022 Latency SHALL be 1 cycle from unit_ack to commit_valid; throughput SHALL be 1 result per cycle when commit_ready is held at 1.
REQ-023 ptr SHALL update to (granted index + 1) mod NUM_UNITS only on a cycle where unit_ack is non-zero; otherwise it SHALL hold.
REQ-024 commit_count SHALL increment by 1 on each cycle with commit_valid && commit_ready, wrapping from all-ones to 0.
REQ-025 A simultaneous drain and fill (commit_valid=1, commit_ready=1, unit_done non-zero) SHALL both pop the old result and load the new one in the same cycle.
REQ-026 The block SHALL tolerate unit_done that stays asserted across cycles without ack; a unit SHALL be acked at most once per result.

Reset
REQ-027 While rst=0: commit_valid=0, unit_ack=0 (combinationally), ptr=0, commit_count=0, commit_rd=0, commit_id=0, commit_special=0.
REQ-028 Assertion of reset mid-operation SHALL discard any held result without committing it; operation SHALL resume on the first clock edge after rst rises.

Structure
REQ-029 flopoco_t and id_t SHALL be taken from the shared cva5_types/FPU package; the special-class encoding constant (2'b01 = normal) SHALL live in the same package.
REQ-030 The round-robin selector SHALL be a sub-module named rr_grant (inputs: requests and ptr; outputs: one-hot grant and encoded index).

Verification
REQ-031 After reset, unit_done=2'b01, rd=34'h1_3F80_0000, id=3, ready=1 -> ack=2'b01 in the same cycle; next cycle commit_valid=1, commit_rd=34'h1_3F80_0000, id=3, special=0.
REQ-032 With both units done continuously for 4 cycles and ready=1 -> acks alternate 01,10,01,10; commit_count=3 after the third commit.
REQ-033 commit_valid=1 with ready=0 for 3 cycles while unit 1 is done -> ack=0 and payload stable for all 3 cycles; the cycle ready=1, ack=2'b10 and the new payload appear next cycle.
REQ-034 rd=34'h3_7FC0_0000 (NaN class) -> commit_special=1; rd=34'h0_0000_0000 -> commit_special=1.
REQ-035 rst driven low while commit_valid=1 -> commit_valid=0 immediately with no commit counted; ptr=0 after release.
REQ-036 commit_count preloaded via force to all-ones, then one commit -> commit_count=0.
